bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter that uses the shift-add-3 (double-dabble) algorithm.
//  Takes an unsigned binary value (score, lives, timer) and produces one packed
//  4-bit decimal digit per display position. Each digit drives its own 7-segment
//  hex decoder instance downstream.
//  Also produces a leading-zero blanking mask so the top level can turn off unused segments.
// PARAMETERS
//  BIN_W   16  width of binary input
//  DIGITS  5   number of BCD digits out; must satisfy 10**DIGITS > 2**BIN_W-1 (elaboration check)
// PORTS
//  clock      in   1           system clock, all state on rising edge
//  resetn     in   1           asynchronous, active-low reset
//  start      in   1           request conversion of bin_in; sampled only when busy=0
//  bin_in     in   BIN_W       unsigned value, captured on the accepted start edge
//  busy       out  1           conversion in progress
//  done       out  1           one-cycle pulse: bcd_out/digit_lit just updated
//  bcd_out    out  4*DIGITS    packed digits, [3:0]=ones; each nibble 0..9
//  digit_lit  out  DIGITS      1 = display digit i; leading zeros 0; bit0 always 1
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, busy=0, done=0, bcd_out=0, digit_lit={0..,1};
//   shift regs and counter cleared. Reset mid-conversion aborts it; no done is issued.
//  FSM IDLE -> SHIFT -> IDLE:
//   IDLE: start=1 at edge E0 -> capture bin_in into shift reg, clear BCD scratch,
//         cnt=0, go SHIFT; busy=1 after E0.
//   SHIFT: each edge: every scratch nibble >=5 gets +3, then {scratch,bin} <<= 1, cnt++.
//         On the edge where cnt==BIN_W-1 (edge E_BIN_W): load bcd_out/digit_lit from final
//         scratch, done=1, busy=0, go IDLE.
//  Latency: start sampled at E0 -> done high for the cycle after E_BIN_W (BIN_W clocks).
//  done high exactly 1 cycle; deasserts next edge unless another conversion completes.
//  start while busy=1: ignored, not queued; bin_in changes while busy: no effect.
//  start held high: new conversion accepted on first IDLE edge -> back-to-back
//   throughput of one result per BIN_W+1 cycles. start high in the done cycle is accepted.
//  bcd_out/digit_lit are output registers, separate from the scratch regs. They hold the last
//   result and stay stable during conversion; no intermediate values ever appear.
//  digit_lit[i]=1 iff some digit j>=i is nonzero, or i==0 (value 0 shows a single "0").
//  Counter width clog2(BIN_W); no arithmetic overflow possible given DIGITS check.
// STRUCTURE
//  Shared include display_defs.vh: DIGIT_W=4, state encodings ST_IDLE/ST_SHIFT,
//   BLANK_SEG=7'h7f (consumed by the top level when digit_lit=0).
//  One sub-module: bcd_add3 (comb, 4b in -> 4b out, +3 when >=5), DIGITS instances
//   via generate. FSM, counter, scratch and output regs live in bin_to_bcd_seq.
// TESTING
//  1 reset, no start -> bcd_out=0, digit_lit=5'b00001, busy=0, done never asserts.
//  2 start, bin_in=0 -> done exactly 16 cycles after start edge; bcd_out=20'h00000, lit=00001.
//  3 bin_in=1234 -> bcd_out=20'h01234, lit=5'b01111; 65535 -> 20'h65535, lit=11111;
//    9 -> 20'h00009, lit=00001; 10 -> 20'h00010, lit=00011.
//  4 start=1 with 100, pulse start+bin_in=999 mid-busy -> result 20'h00100 only, one done.
//  5 start held high, bin_in 42 then 7 -> two done pulses 17 cycles apart, 00042 then 00007.
//  6 resetn low at shift 8 of 500 -> outputs reset values immediately, no done;
//    new start after release converts correctly. Checker compares all values vs reference model.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its display consumers.
package bin_to_bcd_seq_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [6:0] BLANK_SEG = 7'h7f;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: adds 3 when the nibble is 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] dig_i,
    output logic [DIGIT_W-1:0] dig_o
);

    assign dig_o = (dig_i >= DIGIT_W'(5)) ? dig_i + DIGIT_W'(3) : dig_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: result and done pulse BIN_W clocks after an accepted start.
// start is only sampled while idle; requests made while busy are dropped, not queued.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]         digit_lit
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    localparam logic [63:0] DEC_SPAN = 64'(10) ** DIGITS;
    localparam logic [63:0] BIN_MAX  = (64'(1) << BIN_W) - 64'(1);

    if (DEC_SPAN <= BIN_MAX) begin : g_bad_cfg
        $error("bin_to_bcd_seq: DIGITS too small to hold 2**BIN_W-1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [SCR_W-1:0]   bcd_q,   bcd_d;
    logic [DIGITS-1:0]  lit_q,   lit_d;
    logic               done_q,  done_d;

    logic [SCR_W-1:0]   scr_adj;
    logic [SCR_W-1:0]   scr_next;
    logic [BIN_W-1:0]   bin_next;
    logic [DIGITS-1:0]  lit_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .dig_i (scr_q[g*DIGIT_W +: DIGIT_W]),
            .dig_o (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One double-dabble step: corrected scratch shifts left, taking the binary MSB.
    assign scr_next = {scr_adj[SCR_W-2:0], bin_q[BIN_W-1]};
    assign bin_next = {bin_q[BIN_W-2:0], 1'b0};

    always_comb begin
        logic seen;
        lit_next = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (|scr_next[i*DIGIT_W +: DIGIT_W]);
            lit_next[i] = seen;
        end
        lit_next[0] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scr_d   = scr_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        lit_d   = lit_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scr_d   = '0;
                    bin_d   = bin_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d = scr_next;
                bin_d = bin_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = scr_next;
                    lit_d   = lit_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scr_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            lit_q   <= DIGITS'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scr_q   <= scr_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            lit_q   <= lit_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;
    assign bcd_out   = bcd_q;
    assign digit_lit = lit_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, blanking mask, busy-drop, back-to-back, reset abort.
module tb_bin_to_bcd_seq;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic [4:0]  digit_lit;

    int          errors   = 0;
    int          checks   = 0;
    logic [19:0] last_bcd = '0;

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .digit_lit (digit_lit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_lit(input int v);
        int n;
        int t;
        n = 1;
        t = v / 10;
        while (t > 0) begin
            n++;
            t = t / 10;
        end
        return 5'((1 << n) - 1);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_conv(input string tag, input int v, input logic [19:0] eb, input logic [4:0] el);
        int cyc;
        start  = 1'b1;
        bin_in = 16'(v);
        tick;
        start  = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            check({tag, " hold"}, 32'(bcd_out), 32'(last_bcd));
            tick;
            cyc++;
        end
        check({tag, " latency"}, cyc, 32'd16);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " bcd"}, 32'(bcd_out), 32'(eb));
        check({tag, " lit"}, 32'(digit_lit), 32'(el));
        last_bcd = eb;
        tick;
        check({tag, " done1"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        int vals[5];
        vals = '{255, 4096, 59999, 65534, 100};

        // 1: reset state and no spurious done
        #12;
        check("rst bcd", 32'(bcd_out), 32'h0);
        check("rst lit", 32'(digit_lit), 32'h1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        resetn = 1'b1;
        ndone = 0;
        repeat (20) begin
            tick;
            if (done) ndone++;
        end
        check("idle no done", ndone, 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // 2 and 3: directed values
        run_conv("zero",  0,     20'h00000, 5'b00001);
        run_conv("v1234", 1234,  20'h01234, 5'b01111);
        run_conv("vmax",  65535, 20'h65535, 5'b11111);
        run_conv("v9",    9,     20'h00009, 5'b00001);
        run_conv("v10",   10,    20'h00010, 5'b00011);

        // 4: start pulse with a new value while busy is dropped
        start  = 1'b1;
        bin_in = 16'd100;
        tick;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin
                start  = 1'b1;
                bin_in = 16'd999;
            end else begin
                start  = 1'b0;
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        check("busy_drop latency", cyc, 32'd16);
        check("busy_drop bcd", 32'(bcd_out), 32'h00100);
        check("busy_drop lit", 32'(digit_lit), 32'b00111);
        last_bcd = 20'h00100;
        ndone = 0;
        repeat (20) begin
            tick;
            if (done) ndone++;
        end
        check("busy_drop extra done", ndone, 32'd0);
        check("busy_drop idle", 32'(busy), 32'd0);

        // 5: start held high, back-to-back conversions
        start  = 1'b1;
        bin_in = 16'd42;
        tick;
        bin_in = 16'd7;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick;
            cyc++;
        end
        check("b2b first latency", cyc, 32'd16);
        check("b2b first bcd", 32'(bcd_out), 32'h00042);
        check("b2b first lit", 32'(digit_lit), 32'b00011);
        cyc = 0;
        tick;
        cyc++;
        while (!done && cyc < 40) begin
            tick;
            cyc++;
        end
        start = 1'b0;
        check("b2b spacing", cyc, 32'd17);
        check("b2b second bcd", 32'(bcd_out), 32'h00007);
        check("b2b second lit", 32'(digit_lit), 32'b00001);
        last_bcd = 20'h00007;
        tick;
        check("b2b done1", 32'(done), 32'd0);
        tick;
        check("b2b no restart", 32'(busy), 32'd0);

        // 6: reset mid-conversion aborts, then recovery
        start  = 1'b1;
        bin_in = 16'd500;
        tick;
        start = 1'b0;
        repeat (8) tick;
        #1 resetn = 1'b0;
        #1;
        check("abort bcd", 32'(bcd_out), 32'h0);
        check("abort lit", 32'(digit_lit), 32'h1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        tick;
        resetn = 1'b1;
        last_bcd = '0;
        ndone = 0;
        repeat (20) begin
            tick;
            if (done) ndone++;
        end
        check("abort no done", ndone, 32'd0);
        run_conv("after_rst", 500, 20'h00500, 5'b00111);

        foreach (vals[k]) begin
            run_conv($sformatf("model%0d", vals[k]), vals[k], ref_bcd(vals[k]), ref_lit(vals[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
